add_burst_sequencer: RTL and testbench

Single-clock sequencer that drives one adder test burst on the PLL domain. It issues N consecutive operand-RAM read addresses and generates the matching result-RAM write enable and address, delayed by the fixed adder-path latency. It reports busy, done and an elapsed-cycle count back to the control unit. It sits between the avalon-side control registers (already synchronised into the PLL domain) and the operand/result RAM arithmetic ports.

---
 rtl/add_burst_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_add_burst_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_burst_sequencer.sv
// ---------------------------------------------------------------------------
// add_burst_sequencer
//
// Drives one adder test burst in the PLL clock domain. Issues N consecutive
// operand-RAM read addresses, then replays them LATENCY cycles later as the
// result-RAM write enable and address. Reports busy/done and the number of
// cycles spent in RUN+DRAIN to the control unit.
//
// Ports:
//   pll_clock  in   sole clock, rising edge
//   resetn     in   asynchronous active-low reset
//   start      in   one-cycle burst request, honoured only in IDLE or DONE
//   abort      in   level, forces a return to IDLE and flushes the write path
//   num_ops    in   burst length N (0..2^ADDR_WIDTH), captured on start
//   r_addr     out  operand-RAM read address (shared by A and B)
//   r_en       out  read address valid
//   w_addr     out  result-RAM write address
//   we         out  result-RAM write enable
//   busy       out  high in RUN or DRAIN
//   done       out  high in DONE
//   cycles     out  RUN+DRAIN cycle count of the last/current burst
// ---------------------------------------------------------------------------
module add_burst_sequencer #(
    parameter int ADDR_WIDTH = 11,
    parameter int LATENCY    = 5,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  pll_clock,
    input  logic                  resetn,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH:0]   num_ops,
    output logic [ADDR_WIDTH-1:0] r_addr,
    output logic                  r_en,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic                  we,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  cycles
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = 1;
    localparam logic [ADDR_WIDTH:0]   OPS_ONE    = 1;
    localparam logic [ADDR_WIDTH:0]   OPS_ZERO   = '0;
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE    = 1;
    localparam logic [4:0]            DRAIN_INIT = 5'(LATENCY - 1);
    localparam logic [4:0]            DRAIN_ONE  = 5'd1;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH:0]     num_q, num_d;
    logic [ADDR_WIDTH:0]     rd_cnt_q, rd_cnt_d;
    logic [4:0]              drain_q, drain_d;
    logic [ADDR_WIDTH-1:0]   r_addr_q, r_addr_d;
    logic                    r_en_q, r_en_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [CNT_WIDTH-1:0]    cycles_q, cycles_d;

    // Write-path delay line: the last stage is the registered we/w_addr.
    logic [LATENCY-1:0]      dl_en_q, dl_en_d;
    logic [ADDR_WIDTH-1:0]   dl_addr_q [LATENCY];
    logic [ADDR_WIDTH-1:0]   dl_addr_d [LATENCY];

    always_comb begin
        state_d  = state_q;
        num_d    = num_q;
        rd_cnt_d = rd_cnt_q;
        drain_d  = drain_q;
        r_addr_d = r_addr_q;
        r_en_d   = r_en_q;
        busy_d   = busy_q;
        done_d   = done_q;
        cycles_d = busy_q ? cycles_q + CNT_ONE : cycles_q;

        dl_en_d[0]   = r_en_q;
        dl_addr_d[0] = r_addr_q;
        for (int i = 1; i < LATENCY; i++) begin
            dl_en_d[i]   = dl_en_q[i-1];
            dl_addr_d[i] = dl_addr_q[i-1];
        end

        if (abort) begin
            // Flush everything in flight; the cycle count is kept for readback.
            state_d  = S_IDLE;
            r_en_d   = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b0;
            cycles_d = cycles_q;
            dl_en_d  = '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    // done is cleared on an accepted start and reasserted the
                    // cycle after DONE is entered, so an N=0 burst still shows
                    // a fresh done edge.
                    if (state_q == S_DONE) begin
                        done_d = 1'b1;
                    end
                    if (start) begin
                        num_d    = num_ops;
                        cycles_d = '0;
                        done_d   = 1'b0;
                        if (num_ops != OPS_ZERO) begin
                            state_d  = S_RUN;
                            r_en_d   = 1'b1;
                            r_addr_d = '0;
                            rd_cnt_d = OPS_ONE;
                            busy_d   = 1'b1;
                        end else begin
                            state_d = S_DONE;
                        end
                    end
                end
                S_RUN: begin
                    // r_addr advances after the final read too, so a full-RAM
                    // burst wraps to 0 only once r_en is already low.
                    r_addr_d = r_addr_q + ADDR_ONE;
                    if (rd_cnt_q == num_q) begin
                        state_d = S_DRAIN;
                        r_en_d  = 1'b0;
                        drain_d = DRAIN_INIT;
                    end else begin
                        rd_cnt_d = rd_cnt_q + OPS_ONE;
                    end
                end
                S_DRAIN: begin
                    // The delay line empties exactly LATENCY cycles after the
                    // last read, which is when the final write is on the port.
                    if (drain_q == '0) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        drain_d = drain_q - DRAIN_ONE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge pll_clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            num_q    <= '0;
            rd_cnt_q <= '0;
            drain_q  <= '0;
            r_addr_q <= '0;
            r_en_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cycles_q <= '0;
            dl_en_q  <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                dl_addr_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            num_q    <= num_d;
            rd_cnt_q <= rd_cnt_d;
            drain_q  <= drain_d;
            r_addr_q <= r_addr_d;
            r_en_q   <= r_en_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            cycles_q <= cycles_d;
            dl_en_q  <= dl_en_d;
            for (int i = 0; i < LATENCY; i++) begin
                dl_addr_q[i] <= dl_addr_d[i];
            end
        end
    end

    assign r_addr = r_addr_q;
    assign r_en   = r_en_q;
    assign w_addr = dl_addr_q[LATENCY-1];
    assign we     = dl_en_q[LATENCY-1];
    assign busy   = busy_q;
    assign done   = done_q;
    assign cycles = cycles_q;

endmodule

// File: tb/tb_add_burst_sequencer.sv
// ---------------------------------------------------------------------------
// tb_add_burst_sequencer
//
// Scoreboard bench: each accepted start pushes the expected read and write
// addresses; a negedge monitor pops and compares them as r_en/we appear.
// Burst-level timing and counter values are checked from the main sequence.
// ---------------------------------------------------------------------------
module tb_add_burst_sequencer;

    localparam int AW  = 11;
    localparam int LAT = 5;
    localparam int CW  = 32;

    logic          pll_clock = 1'b0;
    logic          resetn    = 1'b0;
    logic          start     = 1'b0;
    logic          abort     = 1'b0;
    logic [AW:0]   num_ops   = '0;
    logic [AW-1:0] r_addr;
    logic          r_en;
    logic [AW-1:0] w_addr;
    logic          we;
    logic          busy;
    logic          done;
    logic [CW-1:0] cycles;

    add_burst_sequencer #(
        .ADDR_WIDTH (AW),
        .LATENCY    (LAT),
        .CNT_WIDTH  (CW)
    ) dut (
        .pll_clock (pll_clock),
        .resetn    (resetn),
        .start     (start),
        .abort     (abort),
        .num_ops   (num_ops),
        .r_addr    (r_addr),
        .r_en      (r_en),
        .w_addr    (w_addr),
        .we        (we),
        .busy      (busy),
        .done      (done),
        .cycles    (cycles)
    );

    always #5 pll_clock = ~pll_clock;

    int cyc = 0;
    always @(posedge pll_clock) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    int rd_q[$];
    int wr_q[$];
    int rd_cnt, wr_cnt;
    int first_rd, last_rd, first_we, last_we, last_waddr;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic reset_trk();
        rd_q.delete();
        wr_q.delete();
        rd_cnt = 0; wr_cnt = 0;
        first_rd = -1; last_rd = -1; first_we = -1; last_we = -1;
        last_waddr = -1;
    endtask

    // Monitor: compare every read/write address against the scoreboard.
    always @(negedge pll_clock) begin
        if (resetn) begin
            if (r_en) begin
                rd_cnt++;
                if (first_rd < 0) first_rd = cyc;
                last_rd = cyc;
                if (rd_q.size() == 0) check("r_en_unexpected", 1, 0);
                else check("r_addr", r_addr, rd_q.pop_front());
            end
            if (we) begin
                wr_cnt++;
                if (first_we < 0) first_we = cyc;
                last_we = cyc;
                last_waddr = w_addr;
                if (wr_q.size() == 0) check("we_unexpected", 1, 0);
                else check("w_addr", w_addr, wr_q.pop_front());
            end
        end
    end

    // Drive a one-cycle start; returns the cycle T in which start was sampled.
    task automatic pulse_start(input int n, input bit expect_accept, output int t);
        @(negedge pll_clock);
        start   = 1'b1;
        num_ops = (AW+1)'(n);
        t = cyc;
        if (expect_accept) begin
            for (int i = 0; i < n; i++) begin
                rd_q.push_back(i % (1 << AW));
                wr_q.push_back(i % (1 << AW));
            end
        end
        @(negedge pll_clock);
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, output int t_done);
        t_done = -1;
        for (int i = 0; i < max_cyc; i++) begin
            if (done) begin
                t_done = cyc;
                break;
            end
            @(negedge pll_clock);
        end
        if (t_done < 0) check("done_timeout", 0, 1);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge pll_clock);
    endtask

    int t, td, found;

    initial begin
        reset_trk();
        // Reset state
        repeat (3) @(negedge pll_clock);
        check("rst_r_addr", r_addr, 0);
        check("rst_r_en",   r_en,   0);
        check("rst_w_addr", w_addr, 0);
        check("rst_we",     we,     0);
        check("rst_busy",   busy,   0);
        check("rst_done",   done,   0);
        check("rst_cycles", cycles, 0);
        resetn = 1'b1;
        idle_cycles(2);

        // 1. Reset in the middle of RUN (N=10, at the 4th read)
        pulse_start(10, 1'b1, t);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (r_en && r_addr == AW'(3)) found = 1;
            else @(negedge pll_clock);
        end
        check("t1_fourth_read_seen", found, 1);
        #1 resetn = 1'b0;
        #1;
        check("t1_r_en",   r_en,   0);
        check("t1_r_addr", r_addr, 0);
        check("t1_we",     we,     0);
        check("t1_busy",   busy,   0);
        check("t1_done",   done,   0);
        check("t1_cycles", cycles, 0);
        idle_cycles(2);
        reset_trk();
        resetn = 1'b1;
        idle_cycles(20);
        check("t1_no_we_after", wr_cnt, 0);
        check("t1_no_rd_after", rd_cnt, 0);
        check("t1_idle_busy",   busy,   0);
        check("t1_idle_done",   done,   0);

        // 2. N=4 timing
        reset_trk();
        pulse_start(4, 1'b1, t);
        wait_done(50, td);
        check("t2_first_rd", first_rd, t + 1);
        check("t2_last_rd",  last_rd,  t + 4);
        check("t2_first_we", first_we, t + 1 + LAT);
        check("t2_last_we",  last_we,  t + 4 + LAT);
        check("t2_done_at",  td,       t + 4 + LAT + 1);
        check("t2_cycles",   cycles,   9);
        check("t2_wr_cnt",   wr_cnt,   4);
        check("t2_busy",     busy,     0);

        // 3. N=0
        reset_trk();
        pulse_start(0, 1'b1, t);
        @(negedge pll_clock);
        check("t3_done_T+2", done,   1);
        check("t3_cycles",   cycles, 0);
        idle_cycles(10);
        check("t3_no_rd", rd_cnt, 0);
        check("t3_no_we", wr_cnt, 0);

        // 4. Full RAM
        reset_trk();
        pulse_start(1 << AW, 1'b1, t);
        wait_done(3000, td);
        idle_cycles(10);
        check("t4_rd_cnt",   rd_cnt,     2048);
        check("t4_wr_cnt",   wr_cnt,     2048);
        check("t4_last_wa",  last_waddr, 2047);
        check("t4_q_empty",  wr_q.size(), 0);
        check("t4_cycles",   cycles,     2053);
        check("t4_done_at",  td,         t + 2048 + LAT + 1);

        // 5. start during RUN ignored, then restart from DONE
        reset_trk();
        pulse_start(8, 1'b1, t);
        pulse_start(2, 1'b0, td);
        wait_done(60, td);
        idle_cycles(3);
        check("t5_wr_cnt", wr_cnt, 8);
        check("t5_cycles", cycles, 13);
        check("t5_done",   done,   1);
        reset_trk();
        pulse_start(3, 1'b1, t);
        wait_done(60, td);
        check("t5b_wr_cnt",  wr_cnt, 3);
        check("t5b_cycles",  cycles, 8);
        check("t5b_done_at", td,     t + 3 + LAT + 1);

        // 6. abort on the 2nd DRAIN cycle of an N=6 burst
        reset_trk();
        pulse_start(6, 1'b1, t);
        while (cyc < t + 8) @(negedge pll_clock);
        check("t6_in_drain", busy && !r_en, 1);
        abort = 1'b1;
        @(negedge pll_clock);
        abort = 1'b0;
        check("t6_we_low",  we,     0);
        check("t6_busy",    busy,   0);
        check("t6_done",    done,   0);
        check("t6_cycles",  cycles, 7);
        idle_cycles(10);
        check("t6_wr_cnt",  wr_cnt, 3);
        check("t6_done_2",  done,   0);
        check("t6_cycles2", cycles, 7);

        // abort + start together from IDLE
        reset_trk();
        @(negedge pll_clock);
        abort   = 1'b1;
        start   = 1'b1;
        num_ops = (AW+1)'(5);
        @(negedge pll_clock);
        abort = 1'b0;
        start = 1'b0;
        check("t6b_busy", busy, 0);
        check("t6b_r_en", r_en, 0);
        idle_cycles(12);
        check("t6b_no_rd", rd_cnt, 0);
        check("t6b_no_we", wr_cnt, 0);
        check("t6b_done",  done,   0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
